rf_port_arbiter: RTL and testbench

- Shares the single read/write port set of the 2-read/1-write register file (registered reads, write to address 0 discarded) between two requesters.
- Grants one requester per cycle with round-robin fairness and drives the register file port.
- Returns a response strobe to the winner on the cycle its registered operands appear.
- Sits between the register file and its two clients, e.g. an execution sequencer and a debug/load port.

---
 rtl/rf_port_arbiter.sv | 101 ++++++++++
 tb/tb_rf_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin arbiter sharing one 2-read/1-write register file port between two clients.
// Revision: 1.0
`default_nettype none

module rf_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_FILE_SIZE = 16,
  parameter int ADDR_WIDTH    = $clog2(REG_FILE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wen,
  input  logic [ADDR_WIDTH-1:0] req0_addr_write,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [ADDR_WIDTH-1:0] req0_addr_a,
  input  logic [ADDR_WIDTH-1:0] req0_addr_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wen,
  input  logic [ADDR_WIDTH-1:0] req1_addr_write,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [ADDR_WIDTH-1:0] req1_addr_a,
  input  logic [ADDR_WIDTH-1:0] req1_addr_b,

  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_operand_a,
  output logic [DATA_WIDTH-1:0] rsp_operand_b,

  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_addr_write,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [ADDR_WIDTH-1:0] rf_addr_a,
  output logic [ADDR_WIDTH-1:0] rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_operand_a,
  input  logic [DATA_WIDTH-1:0] rf_operand_b
);

  logic r_rr_ptr;
  logic r_rsp0_valid;
  logic r_rsp1_valid;
  logic w_grant0;
  logic w_grant1;

  // Grants are masked during reset so no transfer can be accepted there.
  assign w_grant0 = ~reset & req0_valid & (~req1_valid | ~r_rr_ptr);
  assign w_grant1 = ~reset & req1_valid & (~req0_valid |  r_rr_ptr);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    rf_wen        = 1'b0;
    rf_addr_write = '0;
    rf_data_in    = '0;
    rf_addr_a     = '0;
    rf_addr_b     = '0;
    if (w_grant0) begin
      rf_wen        = req0_wen;
      rf_addr_write = req0_addr_write;
      rf_data_in    = req0_data;
      rf_addr_a     = req0_addr_a;
      rf_addr_b     = req0_addr_b;
    end else if (w_grant1) begin
      rf_wen        = req1_wen;
      rf_addr_write = req1_addr_write;
      rf_data_in    = req1_data;
      rf_addr_a     = req1_addr_a;
      rf_addr_b     = req1_addr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= w_grant0;
      r_rsp1_valid <= w_grant1;
      if (w_grant0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_rr_ptr <= 1'b0;
      end
    end
  end

  // A response registered just before reset rises is dropped rather than delivered.
  assign rsp0_valid    = r_rsp0_valid & ~reset;
  assign rsp1_valid    = r_rsp1_valid & ~reset;
  assign rsp_operand_a = rf_operand_a;
  assign rsp_operand_b = rf_operand_b;

endmodule

`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a register-file model and a response scoreboard.
`default_nettype none

module tb_rf_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_wen;
  logic [3:0] req0_addr_write, req0_addr_a, req0_addr_b;
  logic [7:0] req0_data;
  logic       req1_valid, req1_ready, req1_wen;
  logic [3:0] req1_addr_write, req1_addr_a, req1_addr_b;
  logic [7:0] req1_data;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_operand_a, rsp_operand_b;
  logic       rf_wen;
  logic [3:0] rf_addr_write, rf_addr_a, rf_addr_b;
  logic [7:0] rf_data_in, rf_operand_a, rf_operand_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       client;
    logic [7:0] a;
    logic [7:0] b;
  } rsp_t;
  rsp_t q[$];

  logic [7:0] shadow [16];
  logic [7:0] mem    [16];

  always #5 clk = ~clk;

  rf_port_arbiter #(.DATA_WIDTH(8), .REG_FILE_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr_write(req0_addr_write), .req0_data(req0_data),
    .req0_addr_a(req0_addr_a), .req0_addr_b(req0_addr_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr_write(req1_addr_write), .req1_data(req1_data),
    .req1_addr_a(req1_addr_a), .req1_addr_b(req1_addr_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_operand_a(rsp_operand_a), .rsp_operand_b(rsp_operand_b),
    .rf_wen(rf_wen), .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_operand_a(rf_operand_a), .rf_operand_b(rf_operand_b)
  );

  // Register file: registered reads return the pre-write value; address 0 is read-only zero.
  always @(posedge clk) begin
    rf_operand_a <= mem[rf_addr_a];
    rf_operand_b <= mem[rf_addr_b];
    if (rf_wen && rf_addr_write != 4'd0) mem[rf_addr_write] <= rf_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic w, input logic [3:0] aw,
                      input logic [7:0] d, input logic [3:0] aa, input logic [3:0] ab);
    req0_valid = v; req0_wen = w; req0_addr_write = aw;
    req0_data = d; req0_addr_a = aa; req0_addr_b = ab;
  endtask

  task automatic set1(input logic v, input logic w, input logic [3:0] aw,
                      input logic [7:0] d, input logic [3:0] aa, input logic [3:0] ab);
    req1_valid = v; req1_wen = w; req1_addr_write = aw;
    req1_data = d; req1_addr_a = aa; req1_addr_b = ab;
  endtask

  // One clock: check responses due now, check the expected grant and port mux, advance.
  task automatic cycle(input logic eg0, input logic eg1);
    rsp_t       e;
    logic       w;
    logic [3:0] aw, aa, ab;
    logic [7:0] d;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (reset) begin
        check("rsp0_valid_in_reset", {31'd0, rsp0_valid}, 32'd0);
        check("rsp1_valid_in_reset", {31'd0, rsp1_valid}, 32'd0);
      end else begin
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ~e.client});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e.client});
        check("rsp_operand_a", {24'd0, rsp_operand_a}, {24'd0, e.a});
        check("rsp_operand_b", {24'd0, rsp_operand_b}, {24'd0, e.b});
      end
    end else begin
      check("rsp0_valid_idle", {31'd0, rsp0_valid}, 32'd0);
      check("rsp1_valid_idle", {31'd0, rsp1_valid}, 32'd0);
    end
    check("req0_ready", {31'd0, req0_ready}, {31'd0, eg0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, eg1});
    if (eg0 || eg1) begin
      w  = eg0 ? req0_wen        : req1_wen;
      aw = eg0 ? req0_addr_write : req1_addr_write;
      d  = eg0 ? req0_data       : req1_data;
      aa = eg0 ? req0_addr_a     : req1_addr_a;
      ab = eg0 ? req0_addr_b     : req1_addr_b;
      check("rf_wen", {31'd0, rf_wen}, {31'd0, w});
      check("rf_addr_write", {28'd0, rf_addr_write}, {28'd0, aw});
      check("rf_data_in", {24'd0, rf_data_in}, {24'd0, d});
      check("rf_addr_a", {28'd0, rf_addr_a}, {28'd0, aa});
      check("rf_addr_b", {28'd0, rf_addr_b}, {28'd0, ab});
      e.client = eg1;
      e.a      = shadow[aa];
      e.b      = shadow[ab];
      q.push_back(e);
      if (w && aw != 4'd0) shadow[aw] = d;
    end else begin
      check("rf_wen_nogrant", {31'd0, rf_wen}, 32'd0);
      check("rf_addr_a_nogrant", {28'd0, rf_addr_a}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
    reset = 1'b1;
    set0(1'b1, 1'b1, 4'd2, 8'h77, 4'd0, 4'd0);
    set1(1'b1, 1'b1, 4'd4, 8'h66, 4'd0, 4'd0);
    @(posedge clk); #1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b0;
    set1(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);

    // Client 0 writes r3, then client 1 reads it back
    set0(1'b1, 1'b1, 4'd3, 8'hA5, 4'd0, 4'd0);
    cycle(1'b1, 1'b0);
    set0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    set1(1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 4'd0);
    cycle(1'b0, 1'b1);
    set1(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    cycle(1'b0, 1'b0);

    // Reset, then both clients continuously valid: grants alternate starting with 0
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    reset = 1'b0;
    set0(1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 4'd1);
    set1(1'b1, 1'b1, 4'd7, 8'h11, 4'd3, 4'd7);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    set0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    set1(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    cycle(1'b0, 1'b0);

    // Write-and-read in one request returns the old value; a later read sees the new one
    set0(1'b1, 1'b1, 4'd5, 8'h3C, 4'd5, 4'd7);
    cycle(1'b1, 1'b0);
    set0(1'b1, 1'b0, 4'd0, 8'h00, 4'd5, 4'd3);
    cycle(1'b1, 1'b0);

    // Writes to r0 are dropped
    set0(1'b1, 1'b1, 4'd0, 8'hFF, 4'd1, 4'd2);
    cycle(1'b1, 1'b0);
    set0(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd5);
    cycle(1'b1, 1'b0);
    set0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    cycle(1'b0, 1'b0);

    // Reset the cycle after an accepted request: response lost, no write pulse
    set0(1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 4'd5);
    cycle(1'b1, 1'b0);
    reset = 1'b1;
    set0(1'b1, 1'b1, 4'd9, 8'hEE, 4'd9, 4'd9);
    set1(1'b1, 1'b1, 4'd10, 8'hDD, 4'd9, 4'd9);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b0;
    set0(1'b1, 1'b0, 4'd0, 8'h00, 4'd5, 4'd3);
    set1(1'b1, 1'b0, 4'd0, 8'h00, 4'd7, 4'd9);
    cycle(1'b1, 1'b0);
    set0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    cycle(1'b0, 1'b1);
    set1(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
